alu_op_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the 32-bit 74381-style ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's A/B/S/C_in inputs, one 32-bit pass at a time. It captures the ALU's F/Cout/overflow outputs and presents a registered result with its own handshake. Optional 64-bit mode runs two passes, with carry/borrow propagation done inside the sequencer, because the ALU's F ignores C_in.

---
 rtl/alu_op_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Valid/ready command sequencer driving a 32-bit 74381-style ALU, with a
// registered result handshake. Define ALU_SEQ_WIDE_EN for two-pass 64-bit ops.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_wide,
  input  logic [63:0] cmd_a,
  input  logic [63:0] cmd_b,
  input  logic        cmd_cin,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_s,
  output logic        alu_cin,
  input  logic [31:0] alu_f,
  input  logic        alu_cout,
  input  logic        alu_ovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_cout,
  output logic        res_ovf
);

  localparam int unsigned WORD_W = 32;

  localparam logic [2:0] OP_B_MINUS_A = 3'b001;
  localparam logic [2:0] OP_A_MINUS_B = 3'b010;
  localparam logic [2:0] OP_A_PLUS_B  = 3'b011;
  localparam logic [2:0] OP_PRESET    = 3'b111;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t state, next_state;

  logic              accept_c;
  logic [WORD_W-1:0] drv_a, drv_b;
  logic [2:0]        drv_s;
  logic              drv_cin;

`ifdef ALU_SEQ_WIDE_EN
  logic [2:0]        op_q;
  logic              wide_q;
  logic [WORD_W-1:0] a_hi_q, b_hi_q;
  logic [WORD_W-1:0] lo_q;
  logic              c_q;
  logic              c_c;
  logic [WORD_W-1:0] hi_c;
`else
  logic unused_wide_inputs;
  assign unused_wide_inputs = ^{cmd_wide, cmd_a[63:32], cmd_b[63:32]};
`endif

  assign accept_c = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic and next-cycle ALU drive
  always_comb begin
    next_state = state;
    drv_a      = '0;
    drv_b      = '0;
    drv_s      = 3'b000;
    drv_cin    = 1'b0;
    case (state)
      IDLE: if (accept_c) next_state = LO;
`ifdef ALU_SEQ_WIDE_EN
      LO:   next_state = wide_q ? HI : DONE;
`else
      LO:   next_state = DONE;
`endif
      HI:   next_state = DONE;
      DONE: if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    case (next_state)
      LO: begin
        drv_a   = cmd_a[WORD_W-1:0];
        drv_b   = cmd_b[WORD_W-1:0];
        drv_s   = cmd_op;
        drv_cin = cmd_cin;
      end
`ifdef ALU_SEQ_WIDE_EN
      HI: begin
        drv_a   = a_hi_q;
        drv_b   = b_hi_q;
        drv_s   = op_q;
        drv_cin = c_c;
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_SEQ_WIDE_EN
  // Carry/borrow out of the low word, judged from the low-pass operands and F
  always_comb begin
    c_c = 1'b0;
    case (alu_s)
      OP_A_PLUS_B:  c_c = (alu_f < alu_a);
      OP_A_MINUS_B: c_c = (alu_a < alu_b);
      OP_B_MINUS_A: c_c = (alu_b < alu_a);
      default:      c_c = 1'b0;
    endcase
  end

  // Upper word: ALU F ignores C_in, so the carry is folded in here
  always_comb begin
    hi_c = alu_f;
    case (op_q)
      OP_A_PLUS_B:                hi_c = alu_f + WORD_W'(c_q);
      OP_A_MINUS_B, OP_B_MINUS_A: hi_c = alu_f - WORD_W'(c_q);
      OP_PRESET:                  hi_c = '0;
      default:                    hi_c = alu_f;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 3'b000;
      wide_q <= 1'b0;
      a_hi_q <= '0;
      b_hi_q <= '0;
      lo_q   <= '0;
      c_q    <= 1'b0;
    end else begin
      if (state == IDLE && accept_c) begin
        op_q   <= cmd_op;
        wide_q <= cmd_wide;
        a_hi_q <= cmd_a[63:32];
        b_hi_q <= cmd_b[63:32];
      end
      if (state == LO) begin
        lo_q <= alu_f;
        c_q  <= c_c;
      end
    end
  end
`endif

  // Registered handshake, ALU drive and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= 3'b000;
      alu_cin   <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      cmd_ready <= (next_state == IDLE);
      res_valid <= (next_state == DONE);
      alu_a     <= drv_a;
      alu_b     <= drv_b;
      alu_s     <= drv_s;
      alu_cin   <= drv_cin;
      if (state == LO && next_state == DONE) begin
        res_data <= {32'd0, alu_f};
        res_cout <= alu_cout;
        res_ovf  <= alu_ovf;
      end
`ifdef ALU_SEQ_WIDE_EN
      if (state == HI) begin
        res_data <= {hi_c, lo_q};
        res_cout <= alu_cout;
        res_ovf  <= alu_ovf;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 74381-style ALU model.
// Expectations follow ALU_SEQ_WIDE_EN the same way the RTL does.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic        cmd_wide;
  logic [63:0] cmd_a, cmd_b;
  logic        cmd_cin;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_s;
  logic        alu_cin;
  logic [31:0] alu_f;
  logic        alu_cout, alu_ovf;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic        res_cout, res_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wide(cmd_wide), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  // ALU model; F does not depend on C_in
  always_comb begin
    logic [32:0] sum;
    sum      = 33'd0;
    alu_f    = 32'd0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (alu_s)
      3'b001: begin
        sum = {1'b0, alu_b} + {1'b0, ~alu_a} + 33'd1;
        alu_f = sum[31:0]; alu_cout = sum[32];
        alu_ovf = (alu_b[31] != alu_a[31]) && (alu_f[31] != alu_b[31]);
      end
      3'b010: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_f = sum[31:0]; alu_cout = sum[32];
        alu_ovf = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
      end
      3'b011: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_f = sum[31:0]; alu_cout = sum[32];
        alu_ovf = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
      end
      3'b100: alu_f = alu_a ^ alu_b;
      3'b101: alu_f = alu_a | alu_b;
      3'b110: alu_f = alu_a & alu_b;
      3'b111: alu_f = 32'hFFFF_FFFF;
      default: alu_f = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single edge, then scramble the inputs
  task automatic issue(input logic [2:0] op, input logic wide,
                       input logic [63:0] a, input logic [63:0] b);
    cmd_op = op; cmd_wide = wide; cmd_a = a; cmd_b = b; cmd_cin = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op = 3'b110; cmd_a = 64'hDEAD_BEEF_CAFE_F00D; cmd_b = 64'h1234_5678_9ABC_DEF0;
  endtask

  // Consume the result and confirm the sequencer is back in IDLE
  task automatic drain(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_ready_back"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_wide = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; res_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data",  res_data, 64'd0);
    chk("rst_alu_a",     64'(alu_a), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Narrow add 5+3
    issue(3'b011, 1'b0, 64'd5, 64'd3);
    chk("nadd_lo_alu_a",  64'(alu_a), 64'd5);
    chk("nadd_lo_alu_s",  64'(alu_s), 64'd3);
    chk("nadd_lo_ready",  64'(cmd_ready), 64'd0);
    chk("nadd_lo_valid",  64'(res_valid), 64'd0);
    tick();
    chk("nadd_valid",     64'(res_valid), 64'd1);
    chk("nadd_data",      res_data, 64'h0000_0000_0000_0008);
    chk("nadd_cout",      64'(res_cout), 64'd0);
    chk("nadd_alu_idle",  64'(alu_a), 64'd0);
    drain("nadd");

    // Wide add with carry into the upper word
    issue(3'b011, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1);
    chk("wadd_lo_alu_a", 64'(alu_a), 64'hFFFF_FFFF);
    tick();
`ifdef ALU_SEQ_WIDE_EN
    chk("wadd_hi_valid", 64'(res_valid), 64'd0);
    chk("wadd_hi_cin",   64'(alu_cin), 64'd1);
    chk("wadd_hi_alu_a", 64'(alu_a), 64'd0);
    tick();
    chk("wadd_valid",    64'(res_valid), 64'd1);
    chk("wadd_data",     res_data, 64'h0000_0001_0000_0000);
    chk("wadd_cout",     64'(res_cout), 64'd0);
`else
    chk("wadd_valid",    64'(res_valid), 64'd1);
    chk("wadd_data",     res_data, 64'h0000_0000_0000_0000);
    chk("wadd_cout",     64'(res_cout), 64'd1);
    chk("wadd_alu_a",    64'(alu_a), 64'd0);
`endif
    drain("wadd");

    // Wide A-B with borrow, then B-A on the same operands
    issue(3'b010, 1'b1, 64'h0000_0001_0000_0000, 64'h1);
    tick();
`ifdef ALU_SEQ_WIDE_EN
    tick();
`endif
    chk("wsub_valid", 64'(res_valid), 64'd1);
    chk("wsub_data",  res_data, 64'h0000_0000_FFFF_FFFF);
    drain("wsub");

    issue(3'b001, 1'b1, 64'h0000_0001_0000_0000, 64'h1);
    tick();
`ifdef ALU_SEQ_WIDE_EN
    tick();
    chk("wrsub_data", res_data, 64'hFFFF_FFFF_0000_0001);
`else
    chk("wrsub_data", res_data, 64'h0000_0000_0000_0001);
`endif
    chk("wrsub_valid", 64'(res_valid), 64'd1);
    drain("wrsub");

    // Preset op: upper word forced to zero
    issue(3'b111, 1'b1, 64'h0, 64'h0);
    tick();
`ifdef ALU_SEQ_WIDE_EN
    tick();
`endif
    chk("preset_data", res_data, 64'h0000_0000_FFFF_FFFF);
    drain("preset");

    // Backpressure: XOR result held while res_ready is low
    issue(3'b100, 1'b0, 64'hF0, 64'hFF);
    tick();
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(res_valid), 64'd1);
      chk("bp_data",  res_data, 64'h0F);
      chk("bp_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    cmd_valid = 1'b0;
    drain("bp");
    tick();
    chk("bp_no_accept", 64'(cmd_ready), 64'd1);

    // Reset in the middle of an operation
    issue(3'b011, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1);
`ifdef ALU_SEQ_WIDE_EN
    tick();
`endif
    rst = 1'b1;
    #1;
    chk("mrst_ready", 64'(cmd_ready), 64'd1);
    chk("mrst_valid", 64'(res_valid), 64'd0);
    chk("mrst_data",  res_data, 64'd0);
    chk("mrst_alu_a", 64'(alu_a), 64'd0);
    chk("mrst_cin",   64'(alu_cin), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_valid", 64'(res_valid), 64'd0);
      chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
